// File: rtl/spi_txc_if.sv
// spi_txc_if: parallel word handshake between a word source and the
// serial transmit core. The source owns data/valid, the core owns ready.
interface spi_txc_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/spi_txc.sv
// spi_txc: serial transmit core of the SPI block, running on the receive
// bit clock. Parallel words (8/16/32 bits) arrive over a valid/ready
// handshake and leave one bit per clock on shift_out, MSB- or LSB-first.
// A transfer is spi_tnum data frames, optionally followed by one CRC frame.
// Slots that open with no word available are filled with UNDERRUN_FILL.
// Reset doubles as the per-transfer restart; DONE is held until reset.
module spi_txc #(
  parameter logic [31:0] UNDERRUN_FILL = 32'h0,
  parameter int unsigned TNUM_W        = 13
) (
  input  logic              clk_rx,
  input  logic              spi_rx_rstn,
  input  logic [1:0]        df,
  input  logic              lsbf,
  input  logic [TNUM_W-1:0] spi_tnum,
  input  logic              crc_en,
  input  logic [31:0]       crc_poly,
  spi_txc_if.slave          tx,
  output logic              shift_out,
  output logic              tx_busy,
  output logic              tx_underrun,
  output logic              tx_done,
  output logic [31:0]       tx_crc_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } state_t;

  state_t            state;
  logic [31:0]       sr;
  logic [31:0]       crc;
  logic [4:0]        bit_cnt;
  logic [TNUM_W-1:0] frame_cnt;

  logic [4:0]        last_bit;
  logic [31:0]       width_mask;
  logic              frame_end;
  logic              more_frames;
  logic              tnum_zero;
  logic              crc_fb;
  logic [TNUM_W:0]   frame_cnt_inc;
  logic [31:0]       crc_next;
  logic [31:0]       fill_or_data;
  logic [31:0]       data_load;
  logic [31:0]       crc_load;

  // Places a word in the shift register so that bit 0 goes out first.
  // LSB-first words go in unchanged; MSB-first words have their low W
  // bits mirrored, which is a full 32-bit mirror followed by a right shift
  // that drops the unused upper part of the frame.
  function automatic logic [31:0] order_word(
    input logic [31:0] word,
    input logic [31:0] mask,
    input logic [4:0]  msb_idx,
    input logic        lsb_first
  );
    logic [31:0] rev;
    rev = '0;
    for (int i = 0; i < 32; i++) begin
      rev[i] = word[31-i];
    end
    if (lsb_first) begin
      return word & mask;
    end
    return (rev >> (5'd31 - msb_idx)) & mask;
  endfunction

  // Frame geometry derived from the width select
  always_comb begin
    last_bit   = 5'd31;
    width_mask = 32'hFFFF_FFFF;
    case (df)
      2'b00: begin
        last_bit   = 5'd7;
        width_mask = 32'h0000_00FF;
      end
      2'b01: begin
        last_bit   = 5'd15;
        width_mask = 32'h0000_FFFF;
      end
      default: begin
        last_bit   = 5'd31;
        width_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign frame_end     = (bit_cnt == last_bit);
  assign frame_cnt_inc = {1'b0, frame_cnt} + {{TNUM_W{1'b0}}, 1'b1};
  assign more_frames   = (frame_cnt_inc < {1'b0, spi_tnum});
  assign tnum_zero     = (spi_tnum == '0);

  // The CRC absorbs whatever bit is currently on the line, so the value
  // loaded for the CRC frame already includes the final data bit.
  assign crc_fb   = crc[last_bit] ^ shift_out;
  assign crc_next = ((crc << 1) & width_mask) ^
                    (crc_fb ? (crc_poly & width_mask) : 32'h0);

  assign fill_or_data = tx.tx_valid ? tx.tx_data : UNDERRUN_FILL;
  assign data_load    = order_word(fill_or_data, width_mask, last_bit, lsbf);
  assign crc_load     = order_word(crc_next, width_mask, last_bit, lsbf);

  // Ready depends only on where the core is, never on tx_valid, so a
  // source may look at ready before deciding to present a word.
  assign tx.tx_ready = ((state == ST_IDLE) && !tnum_zero) ||
                       ((state == ST_DATA) && frame_end && more_frames);

  assign tx_crc_data_out = crc;

  // Transfer sequencer: frame loading, bit shifting, CRC and status flags
  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      state       <= ST_IDLE;
      sr          <= '0;
      crc         <= '0;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      shift_out   <= 1'b0;
      tx_busy     <= 1'b0;
      tx_underrun <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          shift_out <= 1'b0;
          if (tnum_zero) begin
            bit_cnt <= '0;
            if (crc_en) begin
              // CRC of an empty transfer is the cleared register
              sr        <= '0;
              shift_out <= 1'b0;
              tx_busy   <= 1'b1;
              state     <= ST_CRC;
            end else begin
              tx_done <= 1'b1;
              state   <= ST_DONE;
            end
          end else if (tx.tx_valid) begin
            sr        <= data_load;
            shift_out <= data_load[0];
            bit_cnt   <= '0;
            frame_cnt <= '0;
            tx_busy   <= 1'b1;
            state     <= ST_DATA;
          end
        end

        ST_DATA: begin
          crc <= crc_next;
          if (frame_end) begin
            bit_cnt <= '0;
            if (more_frames) begin
              // Next slot opens with no gap; an empty slot is filled
              // and still counts as one of the transfer's frames.
              frame_cnt   <= frame_cnt + 1'b1;
              sr          <= data_load;
              shift_out   <= data_load[0];
              tx_underrun <= !tx.tx_valid;
            end else if (crc_en) begin
              sr        <= crc_load;
              shift_out <= crc_load[0];
              state     <= ST_CRC;
            end else begin
              shift_out <= 1'b0;
              tx_busy   <= 1'b0;
              tx_done   <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            bit_cnt   <= bit_cnt + 5'd1;
            sr        <= sr >> 1;
            shift_out <= sr[1];
          end
        end

        ST_CRC: begin
          if (frame_end) begin
            bit_cnt   <= '0;
            shift_out <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
            state     <= ST_DONE;
          end else begin
            bit_cnt   <= bit_cnt + 5'd1;
            sr        <= sr >> 1;
            shift_out <= sr[1];
          end
        end

        ST_DONE: begin
          shift_out <= 1'b0;
          tx_busy   <= 1'b0;
          tx_done   <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txc.sv
// tb_spi_txc: directed bench for the serial transmit core. A bit-queue
// model of each transfer predicts every output cycle by cycle, and a few
// literal serial streams and timings pin the model to known answers.
module tb_spi_txc;
  localparam int          TNUM_W = 13;
  localparam logic [31:0] FILL   = 32'h0;

  logic              clk_rx      = 1'b0;
  logic              spi_rx_rstn = 1'b0;
  logic [1:0]        df          = 2'b00;
  logic              lsbf        = 1'b0;
  logic [TNUM_W-1:0] spi_tnum    = '0;
  logic              crc_en      = 1'b0;
  logic [31:0]       crc_poly    = '0;
  logic              shift_out;
  logic              tx_busy;
  logic              tx_underrun;
  logic              tx_done;
  logic [31:0]       tx_crc_data_out;

  spi_txc_if tx_bus();

  spi_txc #(
    .UNDERRUN_FILL(FILL),
    .TNUM_W(TNUM_W)
  ) dut (
    .clk_rx(clk_rx),
    .spi_rx_rstn(spi_rx_rstn),
    .df(df),
    .lsbf(lsbf),
    .spi_tnum(spi_tnum),
    .crc_en(crc_en),
    .crc_poly(crc_poly),
    .tx(tx_bus.slave),
    .shift_out(shift_out),
    .tx_busy(tx_busy),
    .tx_underrun(tx_underrun),
    .tx_done(tx_done),
    .tx_crc_data_out(tx_crc_data_out)
  );

  // Free-running bit clock
  always #5 clk_rx = ~clk_rx;

  int vectors    = 0;
  int miscompares = 0;

  // Edge counter used to time acceptance and completion
  int cyc = 0;
  always @(posedge clk_rx) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // ---------------- model: a queue of bits still to go on the line -----
  logic [1:0]  mq[$];
  bit          m_started    = 1'b0;
  bit          m_done       = 1'b0;
  bit          m_crc_pushed = 1'b0;
  bit          m_underrun   = 1'b0;
  int          m_frames_left = 0;
  int          m_slots      = 0;
  int          m_accepted   = 0;
  int          accept_cyc   = 0;
  logic [31:0] m_crc        = '0;

  function automatic int widthBits();
    if (df == 2'b00) return 8;
    if (df == 2'b01) return 16;
    return 32;
  endfunction

  function automatic logic [31:0] widthMask();
    if (df == 2'b00) return 32'h0000_00FF;
    if (df == 2'b01) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] crcStep(input logic [31:0] c, input logic b);
    int   w;
    logic fb;
    w  = widthBits();
    fb = c[w-1] ^ b;
    return ((c << 1) & widthMask()) ^ (fb ? (crc_poly & widthMask()) : 32'h0);
  endfunction

  task automatic pushWord(input logic [31:0] word, input bit is_data);
    int w;
    w = widthBits();
    for (int i = 0; i < w; i++) begin
      mq.push_back({is_data, (lsbf ? word[i] : word[w-1-i])});
    end
  endtask

  function automatic logic expReady();
    return (!m_started && (spi_tnum != '0)) ||
           (m_started && (mq.size() == 1) && (m_frames_left > 0));
  endfunction

  function automatic logic expShift();
    return (mq.size() > 0) ? mq[0][0] : 1'b0;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_started     = 1'b0;
    m_done        = 1'b0;
    m_crc_pushed  = 1'b0;
    m_underrun    = 1'b0;
    m_frames_left = 0;
    m_slots       = 0;
    m_accepted    = 0;
    m_crc         = '0;
  endtask

  task automatic modelStep();
    logic [1:0] e;
    m_underrun = 1'b0;
    if (!m_started) begin
      if (spi_tnum == '0) begin
        m_started    = 1'b1;
        m_crc_pushed = 1'b1;
        if (crc_en) pushWord(m_crc, 1'b0);
        else m_done = 1'b1;
      end else if (tx_bus.tx_valid) begin
        m_started     = 1'b1;
        m_frames_left = int'(spi_tnum) - 1;
        m_slots       = 1;
        m_accepted    = 1;
        accept_cyc    = cyc;
        pushWord(tx_bus.tx_data, 1'b1);
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e[1]) m_crc = crcStep(m_crc, e[0]);
      if (mq.size() == 0) begin
        if (m_frames_left > 0) begin
          m_frames_left--;
          m_slots++;
          m_underrun = !tx_bus.tx_valid;
          if (tx_bus.tx_valid) begin
            m_accepted++;
            pushWord(tx_bus.tx_data, 1'b1);
          end else begin
            pushWord(FILL, 1'b1);
          end
        end else if (crc_en && !m_crc_pushed) begin
          m_crc_pushed = 1'b1;
          pushWord(m_crc, 1'b0);
        end else begin
          m_done = 1'b1;
        end
      end
    end
  endtask

  // Model advances on each edge, or clears at once on reset
  initial forever begin
    @(posedge clk_rx or negedge spi_rx_rstn);
    if (!spi_rx_rstn) modelReset();
    else modelStep();
  end

  // ---------------- compare process and stream capture ----------------
  logic [63:0] cap_bits     = '0;
  int          cap_len      = 0;
  int          ready_hi     = 0;
  int          underrun_cnt = 0;
  int          done_cyc     = 0;
  logic        prev_done    = 1'b0;

  initial forever begin
    @(negedge clk_rx);
    checkOutput("shift_out", 64'(shift_out), 64'(expShift()));
    checkOutput("tx_ready", 64'(tx_bus.tx_ready), 64'(expReady()));
    checkOutput("tx_busy", 64'(tx_busy), 64'(mq.size() > 0));
    checkOutput("tx_done", 64'(tx_done), 64'(m_done));
    checkOutput("tx_underrun", 64'(tx_underrun), 64'(m_underrun));
    checkOutput("tx_crc_data_out", 64'(tx_crc_data_out), 64'(m_crc));
    if (spi_rx_rstn) begin
      if (tx_busy) begin
        cap_bits = {cap_bits[62:0], shift_out};
        cap_len++;
      end
      if (tx_bus.tx_ready) ready_hi++;
      if (tx_underrun) underrun_cnt++;
    end
    if (tx_done && !prev_done) done_cyc = cyc;
    prev_done = tx_done;
  end

  // ---------------- stimulus ----------------
  int base_len   = 0;
  int base_ready = 0;
  int base_under = 0;
  int rel_cyc    = 0;

  task automatic checkStream(input string name, input int n, input logic [63:0] lit);
    logic [63:0] mask;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    checkOutput({name, "_len"}, 64'(cap_len - base_len), 64'(n));
    checkOutput(name, cap_bits & mask, lit);
  endtask

  task automatic holdReset(input logic [1:0] d, input logic l,
                           input logic [TNUM_W-1:0] tn, input logic ce,
                           input logic [31:0] poly);
    spi_rx_rstn      = 1'b0;
    tx_bus.tx_valid  = 1'b0;
    tx_bus.tx_data   = '1;
    @(posedge clk_rx); #1;
    df       = d;
    lsbf     = l;
    spi_tnum = tn;
    crc_en   = ce;
    crc_poly = poly;
    @(posedge clk_rx); #1;
    base_len   = cap_len;
    base_ready = ready_hi;
    base_under = underrun_cnt;
    rel_cyc    = cyc;
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic l,
                               input logic [TNUM_W-1:0] tn, input logic ce,
                               input logic [31:0] poly, input int n, input int gap,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2);
    logic [31:0] words [3];
    int cycles;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    holdReset(d, l, tn, ce, poly);
    spi_rx_rstn = 1'b1;
    cycles = 0;
    while (!m_done && cycles < 300) begin
      if (m_accepted < n && m_slots != gap) begin
        tx_bus.tx_valid = 1'b1;
        tx_bus.tx_data  = words[m_accepted];
      end else begin
        tx_bus.tx_valid = 1'b0;
        tx_bus.tx_data  = '1;
      end
      @(posedge clk_rx); #1;
      cycles++;
    end
    tx_bus.tx_valid = 1'b0;
    tx_bus.tx_data  = '1;
    repeat (3) @(posedge clk_rx);
    #1;
    checkOutput("done_held", 64'(tx_done), 64'd1);
  endtask

  initial begin
    int waited;
    tx_bus.tx_valid = 1'b0;
    tx_bus.tx_data  = '1;
    repeat (2) @(posedge clk_rx);
    #1;
    checkOutput("reset_shift_out", 64'(shift_out), 64'd0);
    checkOutput("reset_crc_out", 64'(tx_crc_data_out), 64'd0);

    $display("[TB] 8-bit MSB-first, two frames");
    applyStimulus(2'b00, 1'b0, 13'd2, 1'b0, 32'h0, 2, -1, 32'hA5, 32'h3C, 32'h0);
    checkStream("t1_stream", 16, 64'hA53C);
    checkOutput("t1_done_cycle", 64'(done_cyc - accept_cyc), 64'd17);

    $display("[TB] 16-bit LSB-first, single frame");
    applyStimulus(2'b01, 1'b1, 13'd1, 1'b0, 32'h0, 1, -1, 32'h1234, 32'h0, 32'h0);
    checkStream("t2_stream", 16, 64'h2C48);
    checkOutput("t2_ready_cycles", 64'(ready_hi - base_ready), 64'd1);

    $display("[TB] underrun on second slot");
    applyStimulus(2'b00, 1'b0, 13'd3, 1'b0, 32'h0, 2, 1, 32'hC3, 32'h5A, 32'h0);
    checkStream("t3_stream", 24, 64'hC3005A);
    checkOutput("t3_underruns", 64'(underrun_cnt - base_under), 64'd1);

    $display("[TB] CRC-8 poly 07 over 01");
    applyStimulus(2'b00, 1'b0, 13'd1, 1'b1, 32'h07, 1, -1, 32'h01, 32'h0, 32'h0);
    checkStream("t4_stream", 16, 64'h0107);
    checkOutput("t4_crc_out", 64'(tx_crc_data_out), 64'h07);
    checkOutput("t4_done_cycle", 64'(done_cyc - accept_cyc), 64'd17);

    $display("[TB] reset mid 32-bit frame");
    holdReset(2'b10, 1'b0, 13'd2, 1'b1, 32'h04C1_1DB7);
    tx_bus.tx_valid = 1'b1;
    tx_bus.tx_data  = 32'hDEAD_BEEF;
    spi_rx_rstn     = 1'b1;
    waited = 0;
    while (m_accepted == 0 && waited < 10) begin
      @(posedge clk_rx); #1;
      waited++;
    end
    tx_bus.tx_valid = 1'b0;
    tx_bus.tx_data  = '1;
    repeat (3) @(posedge clk_rx);
    #1;
    checkStream("t5_partial", 3, 64'h6);
    checkOutput("t5_busy_before", 64'(tx_busy), 64'd1);
    spi_rx_rstn = 1'b0;
    #1;
    checkOutput("t5_abort_shift", 64'(shift_out), 64'd0);
    checkOutput("t5_abort_busy", 64'(tx_busy), 64'd0);
    checkOutput("t5_abort_ready", 64'(tx_bus.tx_ready), 64'd1);
    checkOutput("t5_abort_crc", 64'(tx_crc_data_out), 64'd0);
    applyStimulus(2'b00, 1'b0, 13'd1, 1'b1, 32'h07, 1, -1, 32'h01, 32'h0, 32'h0);
    checkStream("t5_restart", 16, 64'h0107);
    checkOutput("t5_restart_crc", 64'(tx_crc_data_out), 64'h07);

    $display("[TB] empty transfer, no CRC");
    applyStimulus(2'b00, 1'b0, 13'd0, 1'b0, 32'h0, 0, -1, 32'h0, 32'h0, 32'h0);
    checkOutput("t6_ready_cycles", 64'(ready_hi - base_ready), 64'd0);
    checkOutput("t6_done_cycle", 64'(done_cyc - rel_cyc), 64'd1);

    $display("[TB] empty transfer with CRC");
    applyStimulus(2'b00, 1'b0, 13'd0, 1'b1, 32'h07, 0, -1, 32'h0, 32'h0, 32'h0);
    checkStream("t7_stream", 8, 64'h0);
    checkOutput("t7_done_cycle", 64'(done_cyc - rel_cyc), 64'd9);
    checkOutput("t7_ready_cycles", 64'(ready_hi - base_ready), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
